cc_sync_fifo: RTL and testbench
===============================

# cc_sync_fifo

Single-clock, parametrised FIFO for the ILA capture and storage path. It generalises the block-RAM FIFO model to any power-of-two depth and any data width, and uses every slot: a FIFO with DEPTH 2^n holds exactly 2^n entries. It adds selectable first-word-fall-through (FWFT) output, a live fill level, static or dynamic almost-flag thresholds, and sticky error flags with explicit clear. It sits between the trigger/sample logic and the readout interface, where both sides run in one clock domain.

## Interface
- WIDTH, 20, data width in bits (1..40)
- DEPTH, 2048, number of entries; power of two, 4..32768
- FWFT, 0, 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
- DYN_STAT_SELECT, 0, 0 = almost thresholds from parameters; 1 = from F_ALMOST_*_OFFSET ports
- ALMOST_FULL_OFFSET, 15'hf, static almost-full threshold
- ALMOST_EMPTY_OFFSET, 15'hf, static almost-empty threshold
- Derived: AW = log2(DEPTH), LW = AW+1

Ports:
- CLK  in  1  single clock, rising edge
- F_RST_N  in  1  reset, synchronous, active-low
- PUSH  in  1  write request
- DI  in  WIDTH  write data
- BM  in  WIDTH  bit mask; 1 = write DI bit, 0 = keep the slot's previous bit
- POP  in  1  read request
- DO  out  WIDTH  read data
- DO_VALID  out  1  DO holds valid data
- ERR_CLR  in  1  clears F_RD_ERROR and F_WR_ERROR
- F_ALMOST_FULL_OFFSET  in  15  dynamic almost-full threshold
- F_ALMOST_EMPTY_OFFSET  in  15  dynamic almost-empty threshold
- F_FULL, F_EMPTY, F_ALMOST_FULL, F_ALMOST_EMPTY  out  1  status flags
- F_RD_ERROR, F_WR_ERROR  out  1  sticky underflow/overflow flags
- F_LEVEL  out  LW  entry count, 0..DEPTH
- F_RD_PTR, F_WR_PTR  out  16  zero-extended AW-bit pointers

## Operation
- Accepted push: PUSH and not F_FULL. The slot at wr_ptr is written with DI under BM. wr_ptr increments, wrapping from DEPTH-1 to 0.
- Accepted pop: POP and not F_EMPTY. rd_ptr increments with the same wrap rule.
- Both accepted in the same cycle: F_LEVEL is unchanged.
- Decisions use the flags registered before the edge:
  - Full, with PUSH and POP: the pop is accepted, the push is rejected, F_WR_ERROR is set, and the level becomes DEPTH-1.
  - Empty, with PUSH and POP: the pop is rejected, F_RD_ERROR is set, the push is accepted, and the level becomes 1.
- F_LEVEL is a registered counter: +1 on push only, −1 on pop only.
- Flags are registered and derived from the next-state level:
  - F_FULL = (level == DEPTH)
  - F_EMPTY = (level == 0)
  - F_ALMOST_FULL = (level >= DEPTH − off_f); an offset larger than DEPTH saturates and the flag is held at 1
  - F_ALMOST_EMPTY = (level < off_e)
  - Offset comparisons use 16-bit unsigned arithmetic.
- Error flags are sticky. ERR_CLR clears them. If ERR_CLR and a new error occur in the same cycle, the error wins.
- Standard mode (FWFT=0):
  - On a pop accepted at edge N, DO is loaded with mem[rd_ptr] at edge N and DO_VALID=1 for the following cycle.
  - DO holds its value otherwise, and DO_VALID is 0.
- FWFT mode:
  - DO = head entry and DO_VALID = !F_EMPTY.
  - POP consumes the displayed word.
  - When the FIFO is empty, DO holds its last value.
- Memory contents are not reset. Reset discards all entries, including in the middle of an operation; any push or pop in the reset cycle is ignored.

## Timing
- Reset values: pointers 0, F_LEVEL 0, F_EMPTY 1, F_FULL 0, F_ALMOST_FULL 0, F_ALMOST_EMPTY (off_e > 0), both errors 0, DO 0, DO_VALID 0.
- Push to visibility:
  - FWFT: a push into an empty FIFO at edge N gives DO_VALID=1 with DO=data in cycle N+1.
  - Standard: F_EMPTY deasserts in cycle N+1, so the earliest pop is at edge N+1 and data appears in cycle N+2.
- Pop to next head (FWFT): a pop at edge N presents the next entry in cycle N+1, giving back-to-back throughput of one word per cycle.
- All flags, F_LEVEL and the pointers update on the same edge as the operation that changes them.
- Dynamic offsets are sampled every cycle and take effect on the next edge.

## Test plan
- Fill and drain (DEPTH=8, WIDTH=8, FWFT=0):
  - Push 0x01..0x08: F_FULL=1 after the 8th, F_LEVEL=8.
  - 9th push: F_WR_ERROR=1, contents unchanged.
  - Pop 8 times: DO = 0x01..0x08, each with a 1-cycle DO_VALID, then F_EMPTY=1.
- Wrap and simultaneous (DEPTH=8):
  - Preload 3 entries, then push+pop for 20 cycles: F_LEVEL stays 3, pointers wrap 7→0, data order is preserved.
  - Full + push + pop: level 7, F_WR_ERROR=1.
  - Empty + push + pop: level 1, F_RD_ERROR=1.
- FWFT (DEPTH=8):
  - Push 0xA5 into empty at edge N: DO=0xA5 with DO_VALID=1 in cycle N+1.
  - Push 0xB6, then pop: DO=0xB6 the next cycle.
  - Pop to empty: DO_VALID=0.
- Bit mask:
  - Push 0xFF with BM=0xFF, pop it, cycle the pointers back to the same slot.
  - Push DI=0x00 with BM=0x0F to that slot: the read returns 0xF0.
- Thresholds (DEPTH=16, DYN_STAT_SELECT=1):
  - Offsets 4/4: F_ALMOST_EMPTY drops when level reaches 4; F_ALMOST_FULL rises at level 12.
  - Change the offset to 2 at level 12: F_ALMOST_FULL=0 on the next edge.
- Errors and reset:
  - After the errors are set, ERR_CLR=1 clears them; ERR_CLR together with an overflow keeps F_WR_ERROR=1.
  - F_RST_N=0 for one edge at level 5 with a push active: F_LEVEL=0, F_EMPTY=1, DO=0, push ignored.

Source files
------------

// File: rtl/cc_sync_fifo.sv
// Single-clock FIFO for the ILA capture path: power-of-two depth, bit-masked writes,
// optional first-word-fall-through output, fill level, almost thresholds and sticky errors.
module cc_sync_fifo #(
  parameter int unsigned WIDTH               = 20,
  parameter int unsigned DEPTH               = 2048,
  parameter bit          FWFT                = 1'b0,
  parameter bit          DYN_STAT_SELECT     = 1'b0,
  parameter logic [14:0] ALMOST_FULL_OFFSET  = 15'hf,
  parameter logic [14:0] ALMOST_EMPTY_OFFSET = 15'hf,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             CLK,
  input  logic             F_RST_N,
  input  logic             PUSH,
  input  logic [WIDTH-1:0] DI,
  input  logic [WIDTH-1:0] BM,
  input  logic             POP,
  output logic [WIDTH-1:0] DO,
  output logic             DO_VALID,
  input  logic             ERR_CLR,
  input  logic [14:0]      F_ALMOST_FULL_OFFSET,
  input  logic [14:0]      F_ALMOST_EMPTY_OFFSET,
  output logic             F_FULL,
  output logic             F_EMPTY,
  output logic             F_ALMOST_FULL,
  output logic             F_ALMOST_EMPTY,
  output logic             F_RD_ERROR,
  output logic             F_WR_ERROR,
  output logic [LW-1:0]    F_LEVEL,
  output logic [15:0]      F_RD_PTR,
  output logic [15:0]      F_WR_PTR
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             wr_err_q, wr_err_d;
  logic             rd_err_q, rd_err_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic             dv_q, dv_d;

  logic             push_acc;
  logic             pop_acc;
  logic [WIDTH-1:0] wr_word;
  logic [15:0]      off_f;
  logic [15:0]      off_e;
  logic [15:0]      level_ext;

  always_comb begin
    push_acc = PUSH && !full_q;
    pop_acc  = POP && !empty_q;
    wr_word  = (DI & BM) | (mem_q[wr_ptr_q] & ~BM);

    wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_acc  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push_acc && !pop_acc) begin
      level_d = level_q + LW'(1);
    end else if (!push_acc && pop_acc) begin
      level_d = level_q - LW'(1);
    end

    off_f     = DYN_STAT_SELECT ? {1'b0, F_ALMOST_FULL_OFFSET}  : {1'b0, ALMOST_FULL_OFFSET};
    off_e     = DYN_STAT_SELECT ? {1'b0, F_ALMOST_EMPTY_OFFSET} : {1'b0, ALMOST_EMPTY_OFFSET};
    level_ext = 16'(level_d);

    full_d   = (level_d == LW'(DEPTH));
    empty_d  = (level_d == '0);
    // An offset beyond the depth would underflow the threshold, so pin the flag high.
    afull_d  = (off_f > 16'(DEPTH)) ? 1'b1 : (level_ext >= (16'(DEPTH) - off_f));
    aempty_d = (level_ext < off_e);

    wr_err_d = (PUSH && full_q)  || (wr_err_q && !ERR_CLR);
    rd_err_d = (POP  && empty_q) || (rd_err_q && !ERR_CLR);

    do_d = do_q;
    dv_d = 1'b0;
    if (FWFT) begin
      dv_d = !empty_d;
      // The new head is the word being written this edge when the FIFO was empty,
      // or held one entry that is being popped; bypass the array in that case.
      if (!empty_d) begin
        do_d = (push_acc && (wr_ptr_q == rd_ptr_d)) ? wr_word : mem_q[rd_ptr_d];
      end
    end else if (pop_acc) begin
      do_d = mem_q[rd_ptr_q];
      dv_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!F_RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= (off_e != 16'd0);
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
      do_q     <= '0;
      dv_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
      do_q     <= do_d;
      dv_q     <= dv_d;
    end
  end

  // Storage is never reset; only the pointers decide what is live.
  always_ff @(posedge CLK) begin
    if (F_RST_N && push_acc) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

  assign DO             = do_q;
  assign DO_VALID       = dv_q;
  assign F_FULL         = full_q;
  assign F_EMPTY        = empty_q;
  assign F_ALMOST_FULL  = afull_q;
  assign F_ALMOST_EMPTY = aempty_q;
  assign F_RD_ERROR     = rd_err_q;
  assign F_WR_ERROR     = wr_err_q;
  assign F_LEVEL        = level_q;
  assign F_RD_PTR       = 16'(rd_ptr_q);
  assign F_WR_PTR       = 16'(wr_ptr_q);

endmodule

// File: tb/tb_cc_sync_fifo.sv
// Bench for cc_sync_fifo: standard and FWFT 8-deep instances share one stimulus stream
// and one reference model; a 16-deep instance exercises dynamic almost thresholds.
module tb_cc_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_i, pop_i, err_clr, push16, pop16;
  logic [7:0]  di_i, bm_i;
  logic [14:0] off_f, off_e;

  logic [7:0]  s_do, f_do, t_do;
  logic        s_dv, f_dv, t_dv;
  logic        s_full, s_empty, s_af, s_ae, s_rerr, s_werr;
  logic        f_full, f_empty, f_af, f_ae, f_rerr, f_werr;
  logic        t_full, t_empty, t_af, t_ae, t_rerr, t_werr;
  logic [3:0]  s_lvl, f_lvl;
  logic [4:0]  t_lvl;
  logic [15:0] s_rp, s_wp, f_rp, f_wp, t_rp, t_wp;

  always #5 clk = ~clk;

  cc_sync_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(1'b0), .DYN_STAT_SELECT(1'b1)) u_std (
    .CLK(clk), .F_RST_N(rst_n), .PUSH(push_i), .DI(di_i), .BM(bm_i), .POP(pop_i),
    .DO(s_do), .DO_VALID(s_dv), .ERR_CLR(err_clr),
    .F_ALMOST_FULL_OFFSET(off_f), .F_ALMOST_EMPTY_OFFSET(off_e),
    .F_FULL(s_full), .F_EMPTY(s_empty), .F_ALMOST_FULL(s_af), .F_ALMOST_EMPTY(s_ae),
    .F_RD_ERROR(s_rerr), .F_WR_ERROR(s_werr), .F_LEVEL(s_lvl),
    .F_RD_PTR(s_rp), .F_WR_PTR(s_wp));

  cc_sync_fifo #(.WIDTH(8), .DEPTH(8), .FWFT(1'b1), .DYN_STAT_SELECT(1'b1)) u_fw (
    .CLK(clk), .F_RST_N(rst_n), .PUSH(push_i), .DI(di_i), .BM(bm_i), .POP(pop_i),
    .DO(f_do), .DO_VALID(f_dv), .ERR_CLR(err_clr),
    .F_ALMOST_FULL_OFFSET(off_f), .F_ALMOST_EMPTY_OFFSET(off_e),
    .F_FULL(f_full), .F_EMPTY(f_empty), .F_ALMOST_FULL(f_af), .F_ALMOST_EMPTY(f_ae),
    .F_RD_ERROR(f_rerr), .F_WR_ERROR(f_werr), .F_LEVEL(f_lvl),
    .F_RD_PTR(f_rp), .F_WR_PTR(f_wp));

  cc_sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1'b0), .DYN_STAT_SELECT(1'b1)) u_t16 (
    .CLK(clk), .F_RST_N(rst_n), .PUSH(push16), .DI(di_i), .BM(bm_i), .POP(pop16),
    .DO(t_do), .DO_VALID(t_dv), .ERR_CLR(err_clr),
    .F_ALMOST_FULL_OFFSET(off_f), .F_ALMOST_EMPTY_OFFSET(off_e),
    .F_FULL(t_full), .F_EMPTY(t_empty), .F_ALMOST_FULL(t_af), .F_ALMOST_EMPTY(t_ae),
    .F_RD_ERROR(t_rerr), .F_WR_ERROR(t_werr), .F_LEVEL(t_lvl),
    .F_RD_PTR(t_rp), .F_WR_PTR(t_wp));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the 8-deep FIFO; exp_q holds the live entries in order.
  logic [7:0] exp_q[$];
  logic [7:0] m_mem [8];
  int         m_lvl, m_wr, m_rd;
  logic       m_werr, m_rerr, m_dv;
  logic [7:0] m_do, m_fw_do;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int  of, oe;
    logic m_af, m_ae;
    of   = int'(off_f);
    oe   = int'(off_e);
    m_af = (of > 8) ? 1'b1 : (m_lvl >= 8 - of);
    m_ae = (m_lvl < oe);
    chk("std_level", s_lvl, m_lvl);
    chk("std_full", s_full, m_lvl == 8);
    chk("std_empty", s_empty, m_lvl == 0);
    chk("std_afull", s_af, m_af);
    chk("std_aempty", s_ae, m_ae);
    chk("std_wr_err", s_werr, m_werr);
    chk("std_rd_err", s_rerr, m_rerr);
    chk("std_rd_ptr", s_rp, m_rd);
    chk("std_wr_ptr", s_wp, m_wr);
    chk("std_do", s_do, m_do);
    chk("std_do_valid", s_dv, m_dv);
    chk("fw_level", f_lvl, m_lvl);
    chk("fw_full", f_full, m_lvl == 8);
    chk("fw_empty", f_empty, m_lvl == 0);
    chk("fw_wr_err", f_werr, m_werr);
    chk("fw_rd_err", f_rerr, m_rerr);
    chk("fw_do", f_do, m_fw_do);
    chk("fw_do_valid", f_dv, exp_q.size() > 0);
  endtask

  // Drive one cycle, advance the model across the edge, then compare away from the edge.
  task automatic step(input logic push, input logic pop, input logic [7:0] di, input logic [7:0] bm);
    logic       was_full, was_empty;
    logic [7:0] w;
    push_i = push;
    pop_i  = pop;
    di_i   = di;
    bm_i   = bm;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      m_lvl = 0; m_wr = 0; m_rd = 0;
      m_werr = 1'b0; m_rerr = 1'b0; m_dv = 1'b0;
      m_do = 8'h00; m_fw_do = 8'h00;
    end else begin
      was_full  = (m_lvl == 8);
      was_empty = (m_lvl == 0);
      if (err_clr) begin
        m_werr = 1'b0;
        m_rerr = 1'b0;
      end
      m_dv = 1'b0;
      if (pop && was_empty) m_rerr = 1'b1;
      if (push && was_full) m_werr = 1'b1;
      if (pop && !was_empty) begin
        m_do  = exp_q.pop_front();
        m_dv  = 1'b1;
        m_rd  = (m_rd + 1) % 8;
        m_lvl = m_lvl - 1;
      end
      if (push && !was_full) begin
        w = (di & bm) | (m_mem[m_wr] & ~bm);
        m_mem[m_wr] = w;
        exp_q.push_back(w);
        m_wr  = (m_wr + 1) % 8;
        m_lvl = m_lvl + 1;
      end
      if (exp_q.size() > 0) m_fw_do = exp_q[0];
    end
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] r;
    rst_n = 1'b0; push_i = 1'b0; pop_i = 1'b0; di_i = 8'h00; bm_i = 8'hFF;
    err_clr = 1'b0; push16 = 1'b0; pop16 = 1'b0; off_f = 15'd4; off_e = 15'd4;
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;

    // Reset, with a push held during reset that must be ignored.
    step(1'b0, 1'b0, 8'h00, 8'hFF);
    step(1'b1, 1'b0, 8'h33, 8'hFF);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 8'hFF);
    chk("rst_empty", s_empty, 1'b1);
    chk("rst_aempty", s_ae, 1'b1);

    // Fill, overflow, drain.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i), 8'hFF);
    chk("fill_full", s_full, 1'b1);
    chk("fill_level", s_lvl, 4'd8);
    step(1'b1, 1'b0, 8'h99, 8'hFF);
    chk("ovf_wr_err", s_werr, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'h00, 8'hFF);
      chk("drain_do", s_do, 8'(i));
    end
    step(1'b0, 1'b0, 8'h00, 8'hFF);
    chk("drain_empty", s_empty, 1'b1);
    chk("drain_dv_low", s_dv, 1'b0);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00, 8'hFF);
    err_clr = 1'b0;
    chk("clr_wr_err", s_werr, 1'b0);

    // Preload 3, then simultaneous push/pop across the pointer wrap.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'hFF);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'hFF);
    chk("wrap_level", s_lvl, 4'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 8'hFF);

    // Full with push+pop, then empty with push+pop.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 8'hFF);
    step(1'b1, 1'b1, 8'h77, 8'hFF);
    chk("full_pp_level", s_lvl, 4'd7);
    chk("full_pp_wr_err", s_werr, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, 8'hFF);
    step(1'b1, 1'b1, 8'h55, 8'hFF);
    chk("empty_pp_level", s_lvl, 4'd1);
    chk("empty_pp_rd_err", s_rerr, 1'b1);
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    chk("empty_pp_data", s_do, 8'h55);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00, 8'hFF);
    err_clr = 1'b0;

    // ERR_CLR coinciding with a new overflow: the error wins.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 8'hFF);
    err_clr = 1'b1;
    step(1'b1, 1'b0, 8'hEE, 8'hFF);
    chk("clr_vs_ovf", s_werr, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'hFF);
    chk("clr_after", s_werr, 1'b0);
    err_clr = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 8'hFF);

    // FWFT visibility and consumption.
    step(1'b1, 1'b0, 8'hA5, 8'hFF);
    chk("fwft_first_do", f_do, 8'hA5);
    chk("fwft_first_dv", f_dv, 1'b1);
    step(1'b1, 1'b0, 8'hB6, 8'hFF);
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    chk("fwft_next_do", f_do, 8'hB6);
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    chk("fwft_empty_dv", f_dv, 1'b0);
    chk("fwft_hold_do", f_do, 8'hB6);

    // Bit mask: revisit the same slot after one full pointer lap.
    step(1'b1, 1'b0, 8'hFF, 8'hFF);
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'hFF);
      step(1'b0, 1'b1, 8'h00, 8'hFF);
    end
    step(1'b1, 1'b0, 8'h00, 8'h0F);
    chk("mask_fwft", f_do, 8'hF0);
    step(1'b0, 1'b1, 8'h00, 8'hFF);
    chk("mask_std", s_do, 8'hF0);

    // Random traffic with random masks, clears and offsets.
    for (int i = 0; i < 300; i++) begin
      if (i % 16 == 0) begin
        off_f = 15'($urandom_range(0, 10));
        off_e = 15'($urandom_range(0, 10));
      end
      err_clr = ($urandom_range(0, 9) == 0);
      r = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, 8'($urandom_range(0, 255)));
    end
    err_clr = 1'b0;
    off_f = 15'd4;
    off_e = 15'd4;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h00, 8'hFF);

    // Dynamic thresholds on the 16-deep instance.
    for (int k = 1; k <= 12; k++) begin
      push16 = 1'b1;
      step(1'b0, 1'b0, 8'(k), 8'hFF);
      chk("t16_level", t_lvl, 5'(k));
      chk("t16_aempty", t_ae, k < 4);
      chk("t16_afull", t_af, k >= 12);
    end
    push16 = 1'b0;
    off_f = 15'd2;
    step(1'b0, 1'b0, 8'h00, 8'hFF);
    chk("t16_afull_off2", t_af, 1'b0);
    chk("t16_level_hold", t_lvl, 5'd12);
    off_f = 15'd4;

    // Reset in the middle of traffic at level 5 with a push active.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 8'hFF);
    chk("pre_rst_level", s_lvl, 4'd5);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 8'hDD, 8'hFF);
    rst_n = 1'b1;
    chk("mid_rst_level", s_lvl, 4'd0);
    chk("mid_rst_empty", s_empty, 1'b1);
    chk("mid_rst_do", s_do, 8'h00);
    chk("mid_rst_fw_do", f_do, 8'h00);
    chk("mid_rst_t16", t_lvl, 5'd0);
    step(1'b0, 1'b0, 8'h00, 8'hFF);
    chk("post_rst_level", s_lvl, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
